// File: rtl/commit_trace_collector.sv
// Observer for the CPU commit/monitor tap: trace FIFO, shadow register file
// and saturating pipeline-event counters. Never back-pressures the core.
module commit_trace_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [31:0]               commit_wdata,
  input  logic [1:0]                mon_forwardA,
  input  logic [1:0]                mon_forwardB,
  input  logic                      mon_stall,
  input  logic                      mon_branch_taken,
  input  logic                      enable,
  input  logic                      clear,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [15:0]               trc_seq,
  output logic [4:0]                trc_rd,
  output logic [31:0]               trc_wdata,
  input  logic [4:0]                q_addr,
  output logic [31:0]               q_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      ovf,
  output logic [CNT_W-1:0]          cnt_commit,
  output logic [CNT_W-1:0]          cnt_stall,
  output logic [CNT_W-1:0]          cnt_branch,
  output logic [CNT_W-1:0]          cnt_fwd,
  output logic [CNT_W-1:0]          cnt_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  logic [15:0]     fifo_seq_q   [DEPTH];
  logic [4:0]      fifo_rd_q    [DEPTH];
  logic [31:0]     fifo_wdata_q [DEPTH];
  logic [31:0]     shadow_q     [32];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     seq_q, seq_d;
  logic            ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_commit_q, cnt_commit_d, cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d, cnt_fwd_q, cnt_fwd_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  logic acc_s, pop_s, push_s, drop_s, full_s, fwd_any_s, valid_s;

  assign valid_s   = (level_q != LW'(0));
  assign full_s    = (level_q == FULL_LVL);
  assign acc_s     = enable & commit_valid & (commit_rd != 5'd0);
  assign pop_s     = valid_s & trc_ready;
  // A full FIFO still takes the record if the head leaves in the same cycle.
  assign push_s    = acc_s & (~full_s | pop_s) & ~clear;
  assign drop_s    = acc_s & full_s & ~pop_s;
  assign fwd_any_s = (mon_forwardA != 2'b00) | (mon_forwardB != 2'b00);

  // Next-state for pointers, level, sequence number, overflow flag and counters.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    seq_d        = seq_q;
    ovf_d        = ovf_q;
    cnt_commit_d = cnt_commit_q;
    cnt_stall_d  = cnt_stall_q;
    cnt_branch_d = cnt_branch_q;
    cnt_fwd_d    = cnt_fwd_q;
    cnt_drop_d   = cnt_drop_q;
    if (clear) begin
      wr_ptr_d     = AW'(0);
      rd_ptr_d     = AW'(0);
      level_d      = LW'(0);
      seq_d        = 16'd0;
      ovf_d        = 1'b0;
      cnt_commit_d = CNT_W'(0);
      cnt_stall_d  = CNT_W'(0);
      cnt_branch_d = CNT_W'(0);
      cnt_fwd_d    = CNT_W'(0);
      cnt_drop_d   = CNT_W'(0);
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (acc_s) begin
        seq_d = seq_q + 16'd1;
      end else begin
        seq_d = seq_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      cnt_commit_d = sat_inc(cnt_commit_q, acc_s);
      cnt_stall_d  = sat_inc(cnt_stall_q, enable & mon_stall);
      cnt_branch_d = sat_inc(cnt_branch_q, enable & mon_branch_taken);
      cnt_fwd_d    = sat_inc(cnt_fwd_q, enable & fwd_any_s);
      cnt_drop_d   = sat_inc(cnt_drop_q, drop_s);
    end
  end

  // Control and counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      level_q      <= LW'(0);
      seq_q        <= 16'd0;
      ovf_q        <= 1'b0;
      cnt_commit_q <= CNT_W'(0);
      cnt_stall_q  <= CNT_W'(0);
      cnt_branch_q <= CNT_W'(0);
      cnt_fwd_q    <= CNT_W'(0);
      cnt_drop_q   <= CNT_W'(0);
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      seq_q        <= seq_d;
      ovf_q        <= ovf_d;
      cnt_commit_q <= cnt_commit_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_fwd_q    <= cnt_fwd_d;
      cnt_drop_q   <= cnt_drop_d;
    end
  end

  // Trace FIFO storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_seq_q[wr_ptr_q]   <= seq_q;
      fifo_rd_q[wr_ptr_q]    <= commit_rd;
      fifo_wdata_q[wr_ptr_q] <= commit_wdata;
    end
  end

  // Shadow register file, cleared by both reset and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
    end else if (clear) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
    end else if (acc_s) begin
      shadow_q[commit_rd] <= commit_wdata;
    end
  end

  assign trc_valid  = valid_s;
  // Head fields are forced to zero when empty so reset/clear show all-zero outputs.
  assign trc_seq    = valid_s ? fifo_seq_q[rd_ptr_q]   : 16'd0;
  assign trc_rd     = valid_s ? fifo_rd_q[rd_ptr_q]    : 5'd0;
  assign trc_wdata  = valid_s ? fifo_wdata_q[rd_ptr_q] : 32'd0;
  assign q_data     = (q_addr == 5'd0) ? 32'd0 : shadow_q[q_addr];
  assign fifo_level = level_q;
  assign ovf        = ovf_q;
  assign cnt_commit = cnt_commit_q;
  assign cnt_stall  = cnt_stall_q;
  assign cnt_branch = cnt_branch_q;
  assign cnt_fwd    = cnt_fwd_q;
  assign cnt_drop   = cnt_drop_q;

endmodule

// File: tb/tb_commit_trace_collector.sv
// Self-checking bench: vector table, directed corner sequences and random
// traffic compared against a queue-based reference model.
module tb_commit_trace_collector;

  localparam int DEPTH = 16;

  logic        clk, rst;
  logic        commit_valid, enable, clear, trc_ready, mon_stall, mon_branch_taken;
  logic [4:0]  commit_rd, q_addr;
  logic [31:0] commit_wdata;
  logic [1:0]  mon_forwardA, mon_forwardB;

  logic        trc_valid, ovf;
  logic [15:0] trc_seq;
  logic [4:0]  trc_rd, fifo_level;
  logic [31:0] trc_wdata, q_data;
  logic [31:0] cnt_commit, cnt_stall, cnt_branch, cnt_fwd, cnt_drop;

  logic        d4_valid, d4_ovf;
  logic [15:0] d4_seq;
  logic [4:0]  d4_rd, d4_level;
  logic [31:0] d4_wdata, d4_q;
  logic [3:0]  d4_commit, d4_stall, d4_branch, d4_fwd, d4_drop;

  commit_trace_collector #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_wdata(commit_wdata), .mon_forwardA(mon_forwardA), .mon_forwardB(mon_forwardB),
    .mon_stall(mon_stall), .mon_branch_taken(mon_branch_taken), .enable(enable), .clear(clear),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_seq(trc_seq), .trc_rd(trc_rd),
    .trc_wdata(trc_wdata), .q_addr(q_addr), .q_data(q_data), .fifo_level(fifo_level),
    .ovf(ovf), .cnt_commit(cnt_commit), .cnt_stall(cnt_stall), .cnt_branch(cnt_branch),
    .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop));

  commit_trace_collector #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_wdata(commit_wdata), .mon_forwardA(mon_forwardA), .mon_forwardB(mon_forwardB),
    .mon_stall(mon_stall), .mon_branch_taken(mon_branch_taken), .enable(enable), .clear(clear),
    .trc_valid(d4_valid), .trc_ready(trc_ready), .trc_seq(d4_seq), .trc_rd(d4_rd),
    .trc_wdata(d4_wdata), .q_addr(q_addr), .q_data(d4_q), .fifo_level(d4_level),
    .ovf(d4_ovf), .cnt_commit(d4_commit), .cnt_stall(d4_stall), .cnt_branch(d4_branch),
    .cnt_fwd(d4_fwd), .cnt_drop(d4_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [15:0] seq; logic [4:0] rd; logic [31:0] wd; } rec_t;
  rec_t        mq[$];
  logic [31:0] m_sh [32];
  logic [15:0] m_seq;
  logic        m_ovf;
  longint      raw_commit, raw_stall, raw_branch, raw_fwd, raw_drop;

  function automatic longint sat(input longint raw, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) m_sh[i] = 32'd0;
    m_seq = 16'd0; m_ovf = 1'b0;
    raw_commit = 0; raw_stall = 0; raw_branch = 0; raw_fwd = 0; raw_drop = 0;
  endtask

  task automatic model_step();
    bit pop, acc, was_full;
    if (clear) begin
      model_reset();
    end else begin
      pop = (mq.size() != 0) && trc_ready;
      acc = enable && commit_valid && (commit_rd != 5'd0);
      was_full = (mq.size() == DEPTH);
      if (pop) mq.delete(0);
      if (acc) begin
        m_sh[commit_rd] = commit_wdata;
        raw_commit++;
        if (!was_full || pop) mq.push_back('{m_seq, commit_rd, commit_wdata});
        else begin raw_drop++; m_ovf = 1'b1; end
        m_seq = m_seq + 16'd1;
      end
      if (enable) begin
        raw_stall  += mon_stall;
        raw_branch += mon_branch_taken;
        raw_fwd    += ((mon_forwardA != 2'b00) || (mon_forwardB != 2'b00)) ? 1 : 0;
      end
    end
  endtask

  task automatic check_all();
    chk("trc_valid", trc_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("trc_seq", trc_seq, mq[0].seq);
      chk("trc_rd", trc_rd, mq[0].rd);
      chk("trc_wdata", trc_wdata, mq[0].wd);
    end
    chk("fifo_level", fifo_level, mq.size());
    chk("ovf", ovf, m_ovf);
    chk("q_data", q_data, m_sh[q_addr]);
    chk("cnt_commit", cnt_commit, sat(raw_commit, 32));
    chk("cnt_stall", cnt_stall, sat(raw_stall, 32));
    chk("cnt_branch", cnt_branch, sat(raw_branch, 32));
    chk("cnt_fwd", cnt_fwd, sat(raw_fwd, 32));
    chk("cnt_drop", cnt_drop, sat(raw_drop, 32));
    chk("w4_commit", d4_commit, sat(raw_commit, 4));
    chk("w4_stall", d4_stall, sat(raw_stall, 4));
    chk("w4_branch", d4_branch, sat(raw_branch, 4));
    chk("w4_fwd", d4_fwd, sat(raw_fwd, 4));
    chk("w4_drop", d4_drop, sat(raw_drop, 4));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0; commit_rd = 5'd0; commit_wdata = 32'd0;
    mon_forwardA = 2'b00; mon_forwardB = 2'b00; mon_stall = 1'b0; mon_branch_taken = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  typedef struct {
    logic cv; logic [4:0] rd; logic [31:0] wd; logic rdy; logic [4:0] qa;
    logic e_valid; logic [15:0] e_seq; logic [4:0] e_rd; logic [31:0] e_wd;
    logic [4:0] e_level; logic [31:0] e_q;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd1, 1'b1, 16'd0, 5'd1, 32'h11, 5'd1, 32'h11};
    tbl[1] = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd2, 1'b1, 16'd1, 5'd2, 32'h22, 5'd1, 32'h22};
    tbl[2] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 1'b0, 16'd0, 5'd0, 32'h0,  5'd0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 1'b0, 16'd0, 5'd0, 32'h0,  5'd0, 32'h22};

    idle_inputs(); enable = 1'b1; trc_ready = 1'b0; q_addr = 5'd0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk); rst = 1'b0;

    // Vector table: basic capture and the x0 filter.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      commit_valid = tbl[i].cv; commit_rd = tbl[i].rd; commit_wdata = tbl[i].wd;
      trc_ready = tbl[i].rdy; q_addr = tbl[i].qa;
      tick();
      chk("tbl_valid", trc_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk("tbl_seq", trc_seq, tbl[i].e_seq);
        chk("tbl_rd", trc_rd, tbl[i].e_rd);
        chk("tbl_wdata", trc_wdata, tbl[i].e_wd);
      end
      chk("tbl_level", fifo_level, tbl[i].e_level);
      chk("tbl_q", q_data, tbl[i].e_q);
    end
    chk("basic_cnt_commit", cnt_commit, 32'd2);

    // Overflow: 18 commits into a stalled consumer.
    do_clear();
    trc_ready = 1'b0; q_addr = 5'd18;
    for (int i = 0; i < 18; i++) begin
      commit_valid = 1'b1; commit_rd = 5'(i % 31 + 1); commit_wdata = 32'h1000 + 32'(i);
      tick();
    end
    chk("ovf_level", fifo_level, 5'd16);
    chk("ovf_drop", cnt_drop, 32'd2);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_shadow", q_data, 32'h1011);

    // Full FIFO with simultaneous pop: the commit lands, no drop.
    commit_valid = 1'b1; commit_rd = 5'd5; commit_wdata = 32'hBEEF; trc_ready = 1'b1;
    tick();
    chk("fullpp_level", fifo_level, 5'd16);
    chk("fullpp_drop", cnt_drop, 32'd2);
    commit_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("drain_seq", trc_seq, (k < 15) ? 16'(k + 1) : 16'd18);
      tick();
    end
    chk("drain_empty", trc_valid, 1'b0);

    // Event counters and 4-bit saturation.
    do_clear();
    mon_stall = 1'b1; mon_forwardA = 2'b10; mon_forwardB = 2'b01;
    repeat (3) tick();
    idle_inputs();
    chk("ev_stall", cnt_stall, 32'd3);
    chk("ev_fwd", cnt_fwd, 32'd3);
    mon_branch_taken = 1'b1;
    repeat (20) tick();
    mon_branch_taken = 1'b0;
    chk("sat_branch4", d4_branch, 4'd15);
    chk("branch32", cnt_branch, 32'd20);

    // Clear wins over a same-cycle commit.
    clear = 1'b1; commit_valid = 1'b1; commit_rd = 5'd7; commit_wdata = 32'h77; q_addr = 5'd7;
    tick();
    idle_inputs();
    chk("clr_valid", trc_valid, 1'b0);
    chk("clr_commit", cnt_commit, 32'd0);
    chk("clr_q", q_data, 32'd0);
    chk("clr_branch", cnt_branch, 32'd0);

    // Random traffic: a filling phase then a draining phase.
    for (int c = 0; c < 600; c++) begin
      commit_valid = 1'($urandom_range(0, 1));
      commit_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      commit_wdata = $urandom;
      mon_forwardA = 2'($urandom_range(0, 3));
      mon_forwardB = 2'($urandom_range(0, 3));
      mon_stall = 1'($urandom_range(0, 1));
      mon_branch_taken = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 99) == 0);
      trc_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      q_addr = 5'($urandom_range(0, 31));
      tick();
    end

    // Asynchronous reset in the middle of a drain.
    idle_inputs(); enable = 1'b1;
    do_clear();
    trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      commit_valid = 1'b1; commit_rd = 5'(i + 3); commit_wdata = 32'hA0 + 32'(i);
      tick();
    end
    commit_valid = 1'b0; trc_ready = 1'b1; q_addr = 5'd4;
    tick();
    chk("pre_rst_level", fifo_level, 5'd4);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_commit", cnt_commit, 32'd0);
    chk("rst_q", q_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
